pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline hazard controller for the five-stage core. It generates the `stall`, `interlock` and `taken` controls consumed by the decode→execute pipeline register and the fetch/decode registers. It resolves memory-stall freeze, load-use interlock and branch-mispredict flush with a fixed priority. It also tracks a multi-cycle flush window, a pending redirect across stalls, and a stall watchdog.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 1: number of non-stalled cycles `taken` is held after a redirect (1–15).
- `STALL_TIMEOUT`, default 1024: consecutive stalled cycles before the watchdog fires (2–65535).

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-low reset.
- `valid_D`  in  1  decode stage holds a real instruction.
- `rs1_addr_D`, `rs2_addr_D`  in  5 each  source register addresses in decode.
- `rs1_used_D`, `rs2_used_D`  in  1 each  instruction in decode reads rs1 / rs2.
- `rd_addr_X`  in  5  destination register in execute.
- `rd_write_X`  in  1  execute instruction writes rd.
- `d_re_X`  in  1  execute instruction is a load.
- `br_mispredict_X`  in  1  branch/jump resolved in execute disagrees with the fetched path.
- `icache_stall`, `dcache_stall`  in  1 each  memory not ready (level).
- `stall`  out  1  freeze all pipeline registers.
- `interlock`  out  1  insert a bubble into execute and hold fetch/decode.
- `taken`  out  1  flush decode/execute and redirect fetch.
- `redirect_pending`  out  1  a mispredict is latched and waiting for the stall to clear.
- `stall_timeout`  out  1  sticky watchdog flag.

## Operation
- `stall = icache_stall | dcache_stall`, combinational.
- Priority: stall > taken > interlock. While `stall`=1, `taken`=0 and `interlock`=0.
- Load-use hazard: `hz = valid_D & d_re_X & rd_write_X & (rd_addr_X != 0) & ((rs1_used_D & rs1_addr_D == rd_addr_X) | (rs2_used_D & rs2_addr_D == rd_addr_X))`.
- FSM, states RUN and FLUSH; 4-bit flush counter `fcnt`; pending bit `pend`.
- RUN, `stall`=1: if `br_mispredict_X`, set `pend`. Outputs are stall only.
- RUN, `stall`=0, `br_mispredict_X | pend`: `taken`=1 and `pend` clears.
  - If `FLUSH_CYCLES`>1, go to FLUSH with `fcnt=FLUSH_CYCLES-1`.
  - Otherwise stay in RUN.
- RUN, `stall`=0, no redirect: `interlock=hz`.
- FLUSH: `taken`=1 on every non-stalled cycle, and `fcnt` decrements. On the cycle `fcnt` is 1 and not stalled, return to RUN.
  - Stalled cycles: `taken`=0 and `fcnt` holds.
  - `br_mispredict_X` is ignored, since execute holds bubbles.
  - `interlock`=0.
- `redirect_pending = pend`.
- Watchdog: a 16-bit counter increments on each `stall`=1 cycle and clears on `stall`=0. It saturates at `STALL_TIMEOUT`. Reaching `STALL_TIMEOUT` sets `stall_timeout`, which is cleared only by reset.

## Timing
- `stall`, `interlock` and `taken` are combinational from inputs and current state, with zero latency. State updates on the rising `clk` edge.
- Reset (`rst`=0, async, any cycle): state RUN, `fcnt`=0, `pend`=0, watchdog=0, `stall_timeout`=0, and counters 0.
  - `interlock`, `taken` and `redirect_pending` are 0.
  - `stall` still follows the cache inputs.
- Reset asserted mid-FLUSH aborts the flush immediately. Reset mid-stall drops `pend`.
- Mispredict and stall in the same cycle: `taken` is deferred to the first cycle with `stall`=0.
- Mispredict and load-use hazard in the same cycle: `taken`=1 and `interlock`=0.
- Back-to-back interlocks are allowed. `interlock` stays high while `hz` holds.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: adds outputs `perf_stall_cnt`, `perf_flush_cnt` and `perf_ilock_cnt`, each 32 bits.
  - They count cycles with `stall`, `taken` and `interlock` high respectively.
  - They saturate at all-ones and reset to 0.
- Not defined: the counters and ports are absent, and behaviour is otherwise identical.

## Test plan
- Load x5 in EX (`d_re_X`=1, `rd_addr_X`=5), decode reads rs2=x5 with `rs2_used_D`=1 → `interlock`=1 for that cycle. With `rd_addr_X`=0 → `interlock`=0.
- `FLUSH_CYCLES`=3, `br_mispredict_X` pulsed for one cycle → `taken`=1 for exactly 3 consecutive cycles, then 0, FSM in RUN.
- `dcache_stall`=1 for 4 cycles, with `br_mispredict_X`=1 in the first → `redirect_pending`=1 during the stall. `taken`=1 on the first unstalled cycle, then `redirect_pending`=0.
- In FLUSH with `fcnt`=2, assert `icache_stall` for 2 cycles → `taken`=0 while stalled. Then `taken`=1 for 2 more cycles.
- `STALL_TIMEOUT`=8, `dcache_stall` held 8 cycles → `stall_timeout`=1 after the 8th edge, and it stays 1 after the stall drops until `rst`=0.
- With `HAZARD_PERF_CNT_EN`: 5 stall cycles, 1 flush cycle and 2 interlock cycles → counters read 5, 1 and 2. Asserting `rst` mid-FLUSH → all outputs 0 asynchronously.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: pipeline hazard control. Resolves memory stall, mispredict flush and load-use interlock, in that priority order.
// Latency: stall/interlock/taken are combinational (0 cycles); flush window, pending redirect and watchdog are registered.
// Backpressure: a cache stall freezes everything and defers any redirect until the first unstalled cycle.
// Optional: define HAZARD_PERF_CNT_EN to add the 32-bit saturating stall/flush/interlock cycle counters.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES  = 1,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_D,
  input  logic [4:0] rs1_addr_D,
  input  logic [4:0] rs2_addr_D,
  input  logic       rs1_used_D,
  input  logic       rs2_used_D,
  input  logic [4:0] rd_addr_X,
  input  logic       rd_write_X,
  input  logic       d_re_X,
  input  logic       br_mispredict_X,
  input  logic       icache_stall,
  input  logic       dcache_stall,
  output logic       stall,
  output logic       interlock,
  output logic       taken,
  output logic       redirect_pending,
  output logic       stall_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_ilock_cnt
`endif
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // The first flush cycle is issued from RUN, so FLUSH covers the remaining ones.
  localparam logic [3:0]  FCNT_INIT   = 4'(FLUSH_CYCLES - 1);
  localparam logic        FLUSH_MULTI = (FLUSH_CYCLES > 1);
  localparam logic [15:0] WD_LIMIT    = 16'(STALL_TIMEOUT);

  state_t      state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic        pend_q, pend_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q;
  logic        hz;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        redirect;
  logic        taken_raw;
  logic        ilock_raw;

  // Memory not-ready freezes the whole pipe, independent of controller state.
  assign stall = icache_stall | dcache_stall;

  // Load-use hazard: decode reads the register a load in execute has yet to produce; x0 never hazards.
  always_comb begin
    rs1_hit = rs1_used_D & (rs1_addr_D == rd_addr_X);
    rs2_hit = rs2_used_D & (rs2_addr_D == rd_addr_X);
    hz      = valid_D & d_re_X & rd_write_X & (rd_addr_X != 5'd0) & (rs1_hit | rs2_hit);
  end

  // A redirect comes either from a fresh mispredict or one latched during an earlier stall.
  assign redirect = br_mispredict_X | pend_q;

  // Next-state and raw control outputs; stall dominates, then redirect, then interlock.
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    pend_d    = pend_q;
    taken_raw = 1'b0;
    ilock_raw = 1'b0;
    case (state_q)
      RUN: begin
        if (stall) begin
          if (br_mispredict_X) begin
            pend_d = 1'b1;
          end
        end else if (redirect) begin
          taken_raw = 1'b1;
          pend_d    = 1'b0;
          if (FLUSH_MULTI) begin
            state_d = FLUSH;
            fcnt_d  = FCNT_INIT;
          end
        end else begin
          ilock_raw = hz;
        end
      end
      FLUSH: begin
        // Execute holds bubbles here, so a mispredict from it is meaningless and ignored.
        if (!stall) begin
          taken_raw = 1'b1;
          if (fcnt_q <= 4'd1) begin
            state_d = RUN;
            fcnt_d  = 4'd0;
          end else begin
            fcnt_d = fcnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = 4'd0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // Reset forces the flush/bubble controls low immediately, without waiting for a clock.
  always_comb begin
    taken     = taken_raw & rst;
    interlock = ilock_raw & rst;
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      fcnt_q  <= 4'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
    end
  end

  assign redirect_pending = pend_q;

  // Watchdog next count: counts consecutive stalled cycles, saturating at the limit.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (!stall) begin
      wd_cnt_d = 16'd0;
    end else if (wd_cnt_q != WD_LIMIT) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end
  end

  // Watchdog counter and sticky timeout flag; the flag rises on the edge the count reaches the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (stall && (wd_cnt_d == WD_LIMIT)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign stall_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  // Saturating cycle counters for stall, flush and interlock activity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
      perf_ilock_cnt <= 32'd0;
    end else begin
      if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (taken && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
      if (interlock && (perf_ilock_cnt != 32'hFFFF_FFFF)) begin
        perf_ilock_cnt <= perf_ilock_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
